// File: rtl/key_event_decoder.sv
// Key event decoder: qualifies raw key events, assembles alphabet or morse
// input into a small text buffer, and streams the buffer out on ENTER over a
// valid/ready interface. Control keys edit the buffer or request an exit.
module key_event_decoder #(
    parameter int BUF_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [10:0]                  key_event,
    input  logic                         key_valid,
    input  logic [1:0]                   current_mode,
    input  logic [$clog2(BUF_DEPTH)-1:0] rd_addr,
    output logic [7:0]                   rd_data,
    output logic [$clog2(BUF_DEPTH):0]   buf_len,
    output logic [2:0]                   sym_count,
    output logic                         busy,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    output logic                         tx_last,
    input  logic                         tx_ready,
    output logic                         err,
    output logic                         exit_req
);

    localparam int AW    = $clog2(BUF_DEPTH);
    localparam int LEN_W = AW + 1;

    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BUF_DEPTH);

    localparam logic [1:0] MODE_ALPHA = 2'b00;
    localparam logic [1:0] MODE_MORSE = 2'b01;
    localparam logic [1:0] MODE_SET   = 2'b10;

    localparam logic [10:0] EV_DIT       = {3'b000, 8'h01};
    localparam logic [10:0] EV_DAH_LONG  = {3'b001, 8'h01};
    localparam logic [10:0] EV_DAH_SHORT = {3'b000, 8'h02};
    localparam logic [10:0] EV_SPACE     = {3'b100, 8'h04};
    localparam logic [10:0] EV_CLEAR     = {3'b100, 8'h08};
    localparam logic [10:0] EV_BACK      = {3'b100, 8'h10};
    localparam logic [10:0] EV_ENTER     = {3'b100, 8'h20};
    localparam logic [10:0] EV_EXIT      = {3'b101, 8'h10};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FLUSH = 2'b01,
        ST_SEND  = 2'b10
    } state_t;

    // Morse lookup: returns {known, ascii}; unknown patterns yield '?'.
    // Symbols enter at the LSB, so the first symbol keyed is the MSB of
    // the cnt-bit pattern. Dit = 0, dah = 1.
    function automatic logic [8:0] morse_decode(input logic [4:0] pat,
                                                input logic [2:0] cnt);
        logic [8:0] res;
        res = {1'b0, 8'h3F};
        case (cnt)
            3'd1: begin
                case (pat[0])
                    1'b0:    res = {1'b1, 8'h45}; // E
                    default: res = {1'b1, 8'h54}; // T
                endcase
            end
            3'd2: begin
                case (pat[1:0])
                    2'b00:   res = {1'b1, 8'h49}; // I
                    2'b01:   res = {1'b1, 8'h41}; // A
                    2'b10:   res = {1'b1, 8'h4E}; // N
                    default: res = {1'b1, 8'h4D}; // M
                endcase
            end
            3'd3: begin
                case (pat[2:0])
                    3'b000:  res = {1'b1, 8'h53}; // S
                    3'b001:  res = {1'b1, 8'h55}; // U
                    3'b010:  res = {1'b1, 8'h52}; // R
                    3'b011:  res = {1'b1, 8'h57}; // W
                    3'b100:  res = {1'b1, 8'h44}; // D
                    3'b101:  res = {1'b1, 8'h4B}; // K
                    3'b110:  res = {1'b1, 8'h47}; // G
                    default: res = {1'b1, 8'h4F}; // O
                endcase
            end
            3'd4: begin
                case (pat[3:0])
                    4'b0000: res = {1'b1, 8'h48}; // H
                    4'b0001: res = {1'b1, 8'h56}; // V
                    4'b0010: res = {1'b1, 8'h46}; // F
                    4'b0100: res = {1'b1, 8'h4C}; // L
                    4'b0110: res = {1'b1, 8'h50}; // P
                    4'b0111: res = {1'b1, 8'h4A}; // J
                    4'b1000: res = {1'b1, 8'h42}; // B
                    4'b1001: res = {1'b1, 8'h58}; // X
                    4'b1010: res = {1'b1, 8'h43}; // C
                    4'b1011: res = {1'b1, 8'h59}; // Y
                    4'b1100: res = {1'b1, 8'h5A}; // Z
                    4'b1101: res = {1'b1, 8'h51}; // Q
                    default: res = {1'b0, 8'h3F};
                endcase
            end
            3'd5: begin
                case (pat)
                    5'b01111: res = {1'b1, 8'h31};
                    5'b00111: res = {1'b1, 8'h32};
                    5'b00011: res = {1'b1, 8'h33};
                    5'b00001: res = {1'b1, 8'h34};
                    5'b00000: res = {1'b1, 8'h35};
                    5'b10000: res = {1'b1, 8'h36};
                    5'b11000: res = {1'b1, 8'h37};
                    5'b11100: res = {1'b1, 8'h38};
                    5'b11110: res = {1'b1, 8'h39};
                    5'b11111: res = {1'b1, 8'h30};
                    default:  res = {1'b0, 8'h3F};
                endcase
            end
            default: res = {1'b0, 8'h3F};
        endcase
        return res;
    endfunction

    state_t           state_r;
    logic [7:0]       buf_mem_r [BUF_DEPTH];
    logic [LEN_W-1:0] buf_len_r;
    logic [4:0]       pattern_r;
    logic [2:0]       sym_count_r;
    logic [AW-1:0]    send_idx_r;
    logic             prev_valid_r;
    logic [10:0]      prev_event_r;
    logic             busy_r;
    logic [7:0]       tx_data_r;
    logic             tx_valid_r;
    logic             tx_last_r;
    logic             err_r;
    logic             exit_req_r;

    logic             new_event_s;
    logic             accept_s;
    logic             is_morse_s;
    logic             sym_dit_s;
    logic             sym_dah_s;
    logic             alpha_chr_s;
    logic             ev_space_s;
    logic             ev_clear_s;
    logic             ev_back_s;
    logic             ev_enter_s;
    logic             ev_exit_s;
    logic [8:0]       dec_s;
    logic             app_req_s;
    logic [7:0]       app_char_s;
    logic             app_unknown_s;
    logic             full_s;
    logic             wr_en_s;
    logic             app_err_s;
    logic [LEN_W-1:0] flush_len_s;
    logic [7:0]       first_char_s;
    logic [AW-1:0]    send_nxt_s;
    logic             send_nxt_last_s;

    // Event qualification and classification of accepted events.
    always_comb begin
        new_event_s = key_valid && (!prev_valid_r || (key_event != prev_event_r));
        accept_s    = new_event_s && (state_r == ST_IDLE) && (current_mode != MODE_SET);
        is_morse_s  = (current_mode == MODE_MORSE);
        sym_dit_s   = accept_s && is_morse_s && (key_event == EV_DIT);
        sym_dah_s   = accept_s && is_morse_s &&
                      ((key_event == EV_DAH_LONG) || (key_event == EV_DAH_SHORT));
        alpha_chr_s = accept_s && (current_mode == MODE_ALPHA) &&
                      (key_event[10:8] == 3'b000) &&
                      (key_event[7:0] >= 8'h20) && (key_event[7:0] <= 8'h5A);
        ev_space_s  = accept_s && (key_event == EV_SPACE);
        ev_clear_s  = accept_s && (key_event == EV_CLEAR);
        ev_back_s   = accept_s && (key_event == EV_BACK);
        ev_enter_s  = accept_s && (key_event == EV_ENTER);
        ev_exit_s   = accept_s && (key_event == EV_EXIT);
    end

    // Select the character (if any) appended to the buffer this cycle.
    always_comb begin
        dec_s         = morse_decode(pattern_r, sym_count_r);
        app_req_s     = 1'b0;
        app_char_s    = 8'h00;
        app_unknown_s = 1'b0;
        if (state_r == ST_FLUSH) begin
            app_req_s     = 1'b1;
            app_char_s    = dec_s[7:0];
            app_unknown_s = !dec_s[8];
        end else if (alpha_chr_s) begin
            app_req_s  = 1'b1;
            app_char_s = key_event[7:0];
        end else if (ev_space_s) begin
            app_req_s = 1'b1;
            if (is_morse_s && (sym_count_r != 3'd0)) begin
                app_char_s    = dec_s[7:0];
                app_unknown_s = !dec_s[8];
            end else begin
                app_char_s = 8'h20;
            end
        end else begin
            app_req_s = 1'b0;
        end
        full_s       = (buf_len_r == FULL_LEN);
        wr_en_s      = app_req_s && !full_s;
        app_err_s    = app_req_s && (full_s || app_unknown_s);
        flush_len_s  = wr_en_s ? (buf_len_r + LEN_W'(1)) : buf_len_r;
        first_char_s = (buf_len_r == LEN_W'(0)) ? app_char_s : buf_mem_r[0];
    end

    // Next send index and whether it addresses the final character.
    always_comb begin
        send_nxt_s      = send_idx_r + AW'(1);
        send_nxt_last_s = ({1'b0, send_nxt_s} == (buf_len_r - LEN_W'(1)));
    end

    // Buffer storage: contents are intentionally not reset; rd_data masking hides stale data.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_mem_r[buf_len_r[AW-1:0]] <= app_char_s;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            buf_len_r    <= '0;
            pattern_r    <= 5'd0;
            sym_count_r  <= 3'd0;
            send_idx_r   <= '0;
            prev_valid_r <= 1'b0;
            prev_event_r <= 11'd0;
            busy_r       <= 1'b0;
            tx_data_r    <= 8'h00;
            tx_valid_r   <= 1'b0;
            tx_last_r    <= 1'b0;
            err_r        <= 1'b0;
            exit_req_r   <= 1'b0;
        end else begin
            prev_valid_r <= key_valid;
            prev_event_r <= key_event;
            err_r        <= 1'b0;
            exit_req_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (app_req_s) begin
                        if (wr_en_s) begin
                            buf_len_r <= buf_len_r + LEN_W'(1);
                        end
                        err_r <= app_err_s;
                    end
                    if (sym_dit_s || sym_dah_s) begin
                        if (sym_count_r == 3'd5) begin
                            pattern_r   <= 5'd0;
                            sym_count_r <= 3'd0;
                            err_r       <= 1'b1;
                        end else begin
                            pattern_r   <= {pattern_r[3:0], sym_dah_s};
                            sym_count_r <= sym_count_r + 3'd1;
                        end
                    end else if (ev_space_s) begin
                        pattern_r   <= 5'd0;
                        sym_count_r <= 3'd0;
                    end else if (ev_clear_s) begin
                        buf_len_r   <= '0;
                        pattern_r   <= 5'd0;
                        sym_count_r <= 3'd0;
                    end else if (ev_back_s) begin
                        if (sym_count_r != 3'd0) begin
                            pattern_r   <= 5'd0;
                            sym_count_r <= 3'd0;
                        end else if (buf_len_r != LEN_W'(0)) begin
                            buf_len_r <= buf_len_r - LEN_W'(1);
                        end else begin
                            buf_len_r <= buf_len_r;
                        end
                    end else if (ev_enter_s) begin
                        if (sym_count_r != 3'd0) begin
                            state_r <= ST_FLUSH;
                            busy_r  <= 1'b1;
                        end else if (buf_len_r != LEN_W'(0)) begin
                            state_r    <= ST_SEND;
                            busy_r     <= 1'b1;
                            send_idx_r <= '0;
                            tx_data_r  <= buf_mem_r[0];
                            tx_valid_r <= 1'b1;
                            tx_last_r  <= (buf_len_r == LEN_W'(1));
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else if (ev_exit_s) begin
                        buf_len_r   <= '0;
                        pattern_r   <= 5'd0;
                        sym_count_r <= 3'd0;
                        exit_req_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    pattern_r   <= 5'd0;
                    sym_count_r <= 3'd0;
                    buf_len_r   <= flush_len_s;
                    err_r       <= app_err_s;
                    if (flush_len_s != LEN_W'(0)) begin
                        state_r    <= ST_SEND;
                        busy_r     <= 1'b1;
                        send_idx_r <= '0;
                        tx_data_r  <= first_char_s;
                        tx_valid_r <= 1'b1;
                        tx_last_r  <= (flush_len_s == LEN_W'(1));
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (tx_valid_r && tx_ready) begin
                        if (tx_last_r) begin
                            state_r    <= ST_IDLE;
                            busy_r     <= 1'b0;
                            buf_len_r  <= '0;
                            send_idx_r <= '0;
                            tx_data_r  <= 8'h00;
                            tx_valid_r <= 1'b0;
                            tx_last_r  <= 1'b0;
                        end else begin
                            send_idx_r <= send_nxt_s;
                            tx_data_r  <= buf_mem_r[send_nxt_s];
                            tx_last_r  <= send_nxt_last_s;
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    send_idx_r <= '0;
                    tx_data_r  <= 8'h00;
                    tx_valid_r <= 1'b0;
                    tx_last_r  <= 1'b0;
                end
            endcase
        end
    end

    // Display read port, masked beyond the stored length.
    always_comb begin
        if ({1'b0, rd_addr} < buf_len_r) begin
            rd_data = buf_mem_r[rd_addr];
        end else begin
            rd_data = 8'h00;
        end
    end

    assign buf_len   = buf_len_r;
    assign sym_count = sym_count_r;
    assign busy      = busy_r;
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign tx_last   = tx_last_r;
    assign err       = err_r;
    assign exit_req  = exit_req_r;

endmodule
